// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: round-robin arbiter sharing one bit-serial full adder between two requesters.
//   Ports: clk, rst (sync, active-high); req0/a0/b0, req1/a1/b1 request inputs;
//   grant (one-hot owner), busy, done (1-cycle pulse), done_id, sum, cout (registered).
//   Optional macro ADDER_CIN_EN adds cin0/cin1 carry-in ports captured at accept.
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
`ifdef ADDER_CIN_EN
    input  logic             cin0,
    input  logic             cin1,
`endif
    output logic [1:0]       grant,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic [1:0]       grant_q, grant_d;
    logic             busy_q, busy_d, done_q, done_d, done_id_q, done_id_d, cout_q, cout_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             win, cin_w, fa_s, fa_c;

`ifdef ADDER_CIN_EN
    assign cin_w = win ? cin1 : cin0;
`else
    assign cin_w = 1'b0;
`endif

    // ptr_q names the requester preferred on a tie
    assign win  = (req0 && req1) ? ptr_q : req1;
    assign fa_s = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        if (state_q == IDLE) begin
            if (req0 || req1) begin
                state_d = SHIFT;
                owner_d = win;
                a_d     = win ? a1 : a0;
                b_d     = win ? b1 : b0;
                carry_d = cin_w;
                cnt_d   = '0;
                grant_d = win ? 2'b10 : 2'b01;
                busy_d  = 1'b1;
            end
        end else if (state_q == SHIFT) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            s_d     = {fa_s, s_q[WIDTH-1:1]};
            carry_d = fa_c;
            cnt_d   = cnt_q + CW'(1);
            // the final bit lands directly in the output register so done shows the full sum
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d   = DONE;
                done_d    = 1'b1;
                done_id_d = owner_q;
                sum_d     = {fa_s, s_q[WIDTH-1:1]};
                cout_d    = fa_c;
            end
        end else begin
            state_d = IDLE;
            grant_d = 2'b00;
            busy_d  = 1'b0;
            ptr_d   = ~owner_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            grant_q   <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign sum     = sum_q;
    assign cout    = cout_q;
endmodule
